// File: rtl/sid_i2s_tx_if.sv
// rtl/sid_i2s_tx_if.sv - run/sample inputs and I2S outputs of the SID I2S transmitter
interface sid_i2s_tx_if;
  logic        enable;
  logic [11:0] audio;
  logic        sck;
  logic        ws;
  logic        sd;
  logic        frame_start;

  modport master (
    input  enable,
    input  audio,
    output sck,
    output ws,
    output sd,
    output frame_start
  );

  modport slave (
    output enable,
    output audio,
    input  sck,
    input  ws,
    input  sd,
    input  frame_start
  );
endinterface

// File: rtl/sid_i2s_tx.sv
// rtl/sid_i2s_tx.sv - SID mixer sample to mono Philips I2S master transmitter
// Optional feature macro SID_I2S_AVG_EN: boxcar-average audio over each frame instead of point sampling.
module sid_i2s_tx #(
  parameter int SCK_DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  sid_i2s_tx_if.master bus
);

  localparam int              DIV_W    = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d, bit_cnt_nxt;
  logic [15:0]      word_q, word_d;
  logic [15:0]      point_word, latch_word;
  logic             sck_q, sck_d;
  logic             ws_q, ws_d;
  logic             sd_q, sd_d;
  logic             fs_q, fs_d;
  logic             div_wrap, fall_evt, frame_end;
  logic [3:0]       sd_idx;

  assign point_word  = {bus.audio, 4'b0000} ^ 16'h8000;
  assign div_wrap    = (div_cnt_q == DIV_LAST);
  assign fall_evt    = div_wrap && sck_q;
  assign frame_end   = (state_q == RUN) && fall_evt && (bit_cnt_q == 5'd31);
  assign bit_cnt_nxt = bit_cnt_q + 5'd1;
  // Philips delay: slot bit n carries word bit (16-n) mod 16, so the slot MSB lands one SCK late
  assign sd_idx      = 4'd0 - bit_cnt_nxt[3:0];

`ifdef SID_I2S_AVG_EN
  localparam int ACC_W = 12 + $clog2(64 * SCK_DIV);

  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;

  assign acc_sum    = acc_q + ACC_W'(bus.audio);
  assign latch_word = acc_sum[ACC_W-1 -: 16] ^ 16'h8000;

  always_comb begin
    acc_d = acc_sum;
    if ((state_q == IDLE) || frame_end) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  assign latch_word = point_word;
`endif

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    word_d    = word_q;
    sck_d     = sck_q;
    ws_d      = ws_q;
    sd_d      = sd_q;
    fs_d      = 1'b0;
    case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        bit_cnt_d = '0;
        sck_d     = 1'b0;
        ws_d      = 1'b0;
        sd_d      = 1'b0;
        if (bus.enable) begin
          state_d = RUN;
          word_d  = point_word;
          fs_d    = 1'b1;
        end
      end
      RUN: begin
        div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
        if (div_wrap) begin
          sck_d = ~sck_q;
        end
        if (fall_evt) begin
          bit_cnt_d = bit_cnt_nxt;
          ws_d      = bit_cnt_nxt[4];
          sd_d      = word_q[sd_idx];
          if (frame_end) begin
            if (bus.enable) begin
              word_d = latch_word;
              fs_d   = 1'b1;
            end else begin
              // stopping drops the pending right-slot LSB
              state_d   = IDLE;
              sd_d      = 1'b0;
              div_cnt_d = '0;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      word_q    <= '0;
      sck_q     <= 1'b0;
      ws_q      <= 1'b0;
      sd_q      <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      word_q    <= word_d;
      sck_q     <= sck_d;
      ws_q      <= ws_d;
      sd_q      <= sd_d;
      fs_q      <= fs_d;
    end
  end

  assign bus.sck         = sck_q;
  assign bus.ws          = ws_q;
  assign bus.sd          = sd_q;
  assign bus.frame_start = fs_q;

endmodule
